seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the 4-bit counter value in our counter examples.
- Takes a packed hex value of NUM_DIGITS nibbles and drives a time-multiplexed seven-segment display, one digit at a time.
- Provides refresh prescaling, per-scan snapshotting of the input to prevent tearing, leading-zero blanking and an anti-ghosting guard interval.
- All outputs are registered and drive the board display pins directly.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (must be at least GUARD+1).
- GUARD, 2, cycles at the start of each slot with all digits off (at least 1).
- ACTIVE_LOW, 1. When 1, an/seg/dp are active-low (common-anode board). When 0, they are active-high.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- value, input, 4*NUM_DIGITS, hex value; nibble i is shown on digit i; digit 0 is the rightmost.
- dp_in, input, NUM_DIGITS, decimal-point request per digit.
- blank_lz, input, 1, enables leading-zero blanking.
- an, output, NUM_DIGITS, digit enables; one-hot when a digit is active.
- seg, output, 7, segments {g,f,e,d,c,b,a}.
- dp, output, 1, decimal point.

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high, and sampled on posedge clk only.
- Reset values:
  - Internal state: prescaler pre=0, digit index idx=0, snapshot=0.
  - Outputs at the first edge with rst high: an all inactive, seg all off, dp off. With ACTIVE_LOW=1 that is an=all 1s, seg=7'h7F, dp=1.
- Prescaler:
  - pre counts 0..REFRESH_DIV-1.
  - At pre==REFRESH_DIV-1, pre wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - Slot length is exactly REFRESH_DIV cycles; a full scan is NUM_DIGITS*REFRESH_DIV cycles.
- Snapshot:
  - snapshot<=value on every edge where pre==0 and idx==0, i.e. the first cycle of the digit-0 slot.
  - The first cycle after reset release qualifies.
  - Changes to value mid-scan never affect the current scan.
- Digit selection per cycle: nib = snapshot[4*idx +: 4].
- Blanking:
  - Digit idx is blanked if blank_lz=1, idx>0, and all snapshot nibbles idx..NUM_DIGITS-1 are zero.
  - Digit 0 is never blanked.
- Output registers are computed from the current pre/idx/snapshot, so outputs lag state by one cycle:
  - If pre<GUARD, or the digit is blanked: an all inactive, seg all off, dp off.
  - Otherwise: an has only bit idx active, seg=hex(nib), dp=dp_in[idx]. dp_in is sampled live, not snapshotted.
- The snapshot update edge falls inside the digit-0 guard, so no digit ever shows mixed old/new data.
- Hex encoding, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Polarity: when ACTIVE_LOW=1, an, seg and dp are inverted after encoding.
- Reset mid-scan: the next edge forces reset values; scanning restarts at digit 0 with pre=0 and a fresh snapshot on the first non-reset cycle.
- Width rules:
  - pre width is clog2(REFRESH_DIV); idx width is clog2(NUM_DIGITS), with a minimum of 1.
  - No arithmetic overflow is allowed beyond these wraps.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1.
1. Reset: hold rst 3 cycles with arbitrary value -> an=4'b1111, seg=7'h7F, dp=1 every cycle during reset; first an change after release occurs 3 cycles later.
2. Basic scan: value=16'h1234, dp_in=0, blank_lz=0 -> slots show, in order:
   - an=1110, seg=7'h19;
   - an=1101, seg=7'h30;
   - an=1011, seg=7'h24;
   - an=0111, seg=7'h79;
   - then repeat. Each slot has 2 guard cycles with an=1111 followed by 6 active cycles; the scan period is 32 cycles.
3. Leading-zero blanking: value=16'h0050, blank_lz=1 -> digits 3 and 2 keep an=1111 for their whole slot; digit 1 shows seg=7'h12; digit 0 shows seg=7'h40. With value=0, only digit 0 lights (seg=7'h40). With blank_lz=0, all four digits show 0.
4. Snapshot isolation: value=16'h1234, then change to 16'hABCD during the digit-2 slot -> digits 2 and 3 still show 2 and 1; the next scan shows D (7'h21), C (7'h46), b (7'h03), A (7'h08).
5. Decimal point: dp_in=4'b0100 -> dp=0 only in the active cycles of digit 2's slot, and dp=1 during guard cycles.
6. Reset mid-scan: assert rst for 1 cycle during digit 2's active phase -> outputs go all-off at the next edge; after release, the digit-0 slot starts with 2 guard cycles, and the snapshot reloads from the current value.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bundle of the display-side signals for seg7_scan_driver: the hex value,
// decimal-point and blanking requests going in, and the multiplexed
// anode/segment/decimal-point pins coming out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  // Producer of the value / consumer of the display pins.
  modport master (
    output value, dp_in, blank_lz,
    input  an, seg, dp
  );

  // The scan driver itself.
  modport slave (
    input  value, dp_in, blank_lz,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver. Scans NUM_DIGITS digits,
// one REFRESH_DIV-cycle slot each, with a GUARD-cycle all-off interval at the
// start of every slot to suppress ghosting. The input value is captured once
// per scan (first cycle of the digit-0 slot, inside its guard) so a digit
// never shows a mix of old and new data. All pins are registered.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_driver_if.slave  io_bus
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit POL   = (ACTIVE_LOW != 0);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_pre_last;
  logic                    w_idx_last;
  logic                    w_run;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_lz_sel;
  logic [NUM_DIGITS-1:0]   w_an_1h;
  logic                    w_off;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_seg;
  logic                    w_dp;

  assign w_pre_last = (r_pre == PRE_W'(REFRESH_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index: one slot per REFRESH_DIV cycles, wrap per scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_pre_last) begin
      r_pre <= '0;
      r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Capture the whole value once per scan, at the first cycle of digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if ((r_pre == '0) && (r_idx == '0)) begin
      r_snap <= io_bus.value;
    end
  end

  // w_upper_zero[i]: every snapshot nibble from i up to the top digit is zero.
  always_comb begin
    w_upper_zero = '0;
    w_run        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run           = w_run && (r_snap[4*i +: 4] == 4'h0);
      w_upper_zero[i] = w_run;
    end
  end

  // Select the current digit's nibble, dp request, blanking flag and anode.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    w_an_1h  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib      = r_snap[4*i +: 4];
        w_dp_sel   = io_bus.dp_in[i];
        w_lz_sel   = w_upper_zero[i];
        w_an_1h[i] = 1'b1;
      end
    end
  end

  // Digit 0 is never blanked, so a zero value still shows a single 0.
  assign w_off = (r_pre < PRE_W'(GUARD)) ||
                 (io_bus.blank_lz && (r_idx != '0) && w_lz_sel);
  assign w_an  = w_off ? '0   : w_an_1h;
  assign w_seg = w_off ? 7'h0 : hex_to_seg(w_nib);
  assign w_dp  = w_off ? 1'b0 : w_dp_sel;

  // Registered pins with board polarity applied after encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= {NUM_DIGITS{POL}};
      r_seg <= {7{POL}};
      r_dp  <= POL;
    end else begin
      r_an  <= w_an ^ {NUM_DIGITS{POL}};
      r_seg <= w_seg ^ {7{POL}};
      r_dp  <= w_dp ^ POL;
    end
  end

  assign io_bus.an  = r_an;
  assign io_bus.seg = r_seg;
  assign io_bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle guard,
// active-low pins). A timeline model derives the expected pins of every
// cycle from the elapsed cycle count since reset and the captured value.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GD = 2;

  logic clk;
  logic rst;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GUARD      (GD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles elapsed in the current scan, and the captured value.
  int          m_t    = 0;
  logic [15:0] m_snap = '0;

  logic [6:0] hex_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: predict the pins from the model, then compare.
  task automatic tick();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [15:0] upper;
    int          pre;
    int          idx;
    @(posedge clk);
    if (rst) begin
      e_an   = 4'hF;
      e_seg  = 7'h7F;
      e_dp   = 1'b1;
      m_t    = 0;
      m_snap = '0;
    end else begin
      pre   = m_t % RD;
      idx   = m_t / RD;
      upper = m_snap >> (4 * idx);
      if (pre < GD || (bus.blank_lz && idx > 0 && upper == 16'h0)) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << idx);
        e_seg = ~hex_tbl[upper[3:0]];
        e_dp  = ~bus.dp_in[idx];
      end
      if (m_t == 0) m_snap = bus.value;
      m_t = (m_t + 1) % (ND * RD);
    end
    #1;
    check("an", 16'(bus.an), 16'(e_an));
    check("seg", 16'(bus.seg), 16'(e_seg));
    check("dp", 16'(bus.dp), 16'(e_dp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Random value with a random number of leading zero nibbles.
  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    int          k;
    v = 16'($urandom);
    k = $urandom_range(0, 4);
    for (int j = 0; j < k; j++) v[4*(3-j) +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    rst          = 1'b1;
    bus.value    = 16'($urandom);
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;

    // Reset held for three cycles.
    run(3);
    check("rst_an", 16'(bus.an), 16'hF);
    check("rst_seg", 16'(bus.seg), 16'h7F);
    check("rst_dp", 16'(bus.dp), 16'h1);

    // Basic scan of 1234, then ABCD arriving during digit 2.
    bus.value = 16'h1234;
    rst       = 1'b0;
    run(2);
    check("guard_an", 16'(bus.an), 16'hF);
    run(1);
    check("d0_an", 16'(bus.an), 16'hE);
    check("d0_seg", 16'(bus.seg), 16'h19);
    run(8);
    check("d1_an", 16'(bus.an), 16'hD);
    check("d1_seg", 16'(bus.seg), 16'h30);
    run(8);
    check("d2_an", 16'(bus.an), 16'hB);
    check("d2_seg", 16'(bus.seg), 16'h24);
    bus.value = 16'hABCD;
    run(8);
    check("d3_an", 16'(bus.an), 16'h7);
    check("d3_seg_old", 16'(bus.seg), 16'h79);
    run(8);
    check("d0_seg_new", 16'(bus.seg), 16'h21);
    run(29);

    // Leading-zero blanking of 0050 (snapshot at the next edge).
    bus.value    = 16'h0050;
    bus.blank_lz = 1'b1;
    run(3);
    check("lz_d0_seg", 16'(bus.seg), 16'h40);
    run(8);
    check("lz_d1_seg", 16'(bus.seg), 16'h12);
    run(8);
    check("lz_d2_an", 16'(bus.an), 16'hF);
    run(13);

    // Decimal point on digit 2, then a reset during its active phase.
    rst = 1'b1;
    run(1);
    rst          = 1'b0;
    bus.value    = 16'h1234;
    bus.blank_lz = 1'b0;
    bus.dp_in    = 4'b0100;
    run(17);
    check("dp_guard", 16'(bus.dp), 16'h1);
    run(2);
    check("dp_d2", 16'(bus.dp), 16'h0);
    bus.value = 16'h5678;
    rst       = 1'b1;
    run(1);
    check("mid_rst_an", 16'(bus.an), 16'hF);
    check("mid_rst_seg", 16'(bus.seg), 16'h7F);
    rst = 1'b0;
    run(2);
    check("post_rst_guard", 16'(bus.an), 16'hF);
    run(1);
    check("post_rst_an", 16'(bus.an), 16'hE);
    check("post_rst_seg", 16'(bus.seg), 16'h00);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) bus.value = rand_val();
      if ($urandom_range(0, 19) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
